// File: rtl/fir_ctrl.sv
// AXI-Lite register slave and run sequencer for the FIR engine.
// Owns the tap RAM port: AXI-Lite coefficient access outside RUN, engine fetch during RUN.
module fir_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic [3:0]             eng_tap_idx,
  output logic [pDATA_WIDTH-1:0] eng_coef,
  output logic                   eng_start,
  input  logic                   eng_done,
  output logic [pDATA_WIDTH-1:0] data_length
);
  localparam int WW = pADDR_WIDTH - 2;
  localparam logic [WW-1:0] W_CTRL   = WW'(0);
  localparam logic [WW-1:0] W_LEN    = WW'(4);
  localparam logic [WW-1:0] W_TAP_LO = WW'(8);
  localparam logic [WW-1:0] W_TAP_HI = WW'(8 + Tape_Num);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nx;

  logic [WW-1:0]          aw_word, ar_word;
  logic                   aw_tap, ar_tap, wr_acc, rd_acc, start_wr;
  logic                   ap_idle, ap_done, rd_tap_q, unused_addr_lsb;
  logic [pDATA_WIDTH-1:0] rdata_q, rd_val;

  assign aw_word = awaddr[pADDR_WIDTH-1:2];
  assign ar_word = araddr[pADDR_WIDTH-1:2];
  assign unused_addr_lsb = ^{awaddr[1:0], araddr[1:0]};
  assign aw_tap  = (aw_word >= W_TAP_LO) && (aw_word < W_TAP_HI);
  assign ar_tap  = (ar_word >= W_TAP_LO) && (ar_word < W_TAP_HI);
  assign ap_idle = (state != S_RUN);
  assign ap_done = (state == S_DONE);

  // Write accept is combinational so a tap write lands in the handshake cycle.
  assign wr_acc   = axis_rst_n & awvalid & wvalid;
  // A concurrent write owns the tap port, so the read waits a cycle.
  assign rd_acc   = axis_rst_n & arvalid & ~rvalid & ~wr_acc;
  assign awready  = wr_acc;
  assign wready   = wr_acc;
  assign arready  = rd_acc;
  assign start_wr = wr_acc && (aw_word == W_CTRL) && wdata[0] && (state != S_RUN);

  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_Di = '0;
    tap_A  = '0;
    if (axis_rst_n) begin
      if (state == S_RUN) begin
        tap_EN = 1'b1;
        tap_A  = {{(WW-4){1'b0}}, eng_tap_idx, 2'b00};
      end else if (wr_acc && aw_tap) begin
        tap_EN = 1'b1;
        tap_WE = 4'hF;
        tap_Di = wdata;
        tap_A  = {aw_word - W_TAP_LO, 2'b00};
      end else if (rd_acc && ar_tap) begin
        tap_EN = 1'b1;
        tap_A  = {ar_word - W_TAP_LO, 2'b00};
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (ar_word == W_CTRL) begin
      rd_val[2] = ap_idle;
      rd_val[1] = ap_done;
    end else if (ar_word == W_LEN) begin
      rd_val = data_length;
    end else if (ar_tap && state == S_RUN) begin
      rd_val = '1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_wr) state_nx = S_RUN;
      S_RUN:   if (eng_done) state_nx = S_DONE;
      S_DONE: begin
        if (start_wr)                            state_nx = S_RUN;
        else if (rd_acc && (ar_word == W_CTRL))  state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state       <= S_IDLE;
      eng_start   <= 1'b0;
      data_length <= '0;
      rvalid      <= 1'b0;
      rd_tap_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state     <= state_nx;
      eng_start <= start_wr;
      if (wr_acc && (aw_word == W_LEN) && (state != S_RUN)) data_length <= wdata;
      rd_tap_q <= 1'b0;
      if (rd_tap_q) rdata_q <= tap_Do;
      if (rd_acc) begin
        rvalid   <= 1'b1;
        rd_tap_q <= ar_tap && (state != S_RUN);
        rdata_q  <= rd_val;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // Tap data arrives one cycle after issue: forward it then, hold the captured copy after.
  assign rdata    = rd_tap_q ? tap_Do : rdata_q;
  assign eng_coef = tap_Do;

endmodule
